// File: rtl/uart_apb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_apb_pkg : bus FSM encoding, register indices and bit positions
// Revision     : 1.0
// -----------------------------------------------------------------------------
package uart_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } apb_state_e;

   localparam int unsigned REG_BAUD          = 0;
   localparam int unsigned REG_CTRL          = 1;
   localparam int unsigned REG_TXDATA        = 2;
   localparam int unsigned REG_RXDATA        = 3;
   localparam int unsigned REG_STATUS        = 4;
   localparam int unsigned REG_FIRST_SCRATCH = 5;

   localparam int unsigned CTRL_RX_IE  = 0;
   localparam int unsigned CTRL_TX_IE  = 1;
   localparam int unsigned CTRL_OVR_IE = 2;

   localparam int unsigned STAT_TX_RDY = 0;
   localparam int unsigned STAT_RX_RDY = 1;
   localparam int unsigned STAT_OVR    = 2;

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_wait_ctrl : APB transfer sequencer with programmable access wait states
// Revision      : 1.0
// -----------------------------------------------------------------------------
module apb_wait_ctrl
   import uart_apb_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic psel_i,
   input  logic penable_i,
   output logic idle_o,
   output logic setup_o,
   output logic enter_ready_o,
   output logic pready_o,
   output logic complete_o
);

   localparam logic [3:0] c_wait_last = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   apb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       w_access;

   assign w_access = psel_i & penable_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               cnt_d   = 4'd0;
               state_d = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Dropping psel abandons the transfer before any side effect.
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (w_access) begin
               if (cnt_q == c_wait_last) state_d = ST_READY;
               else                      cnt_d   = cnt_q + 4'd1;
            end
         end
         ST_READY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign idle_o        = (state_q == ST_IDLE);
   assign setup_o       = idle_o & psel_i & ~penable_i;
   assign enter_ready_o = (state_d == ST_READY);
   assign pready_o      = (state_q == ST_READY);
   assign complete_o    = pready_o & w_access;

endmodule
`default_nettype wire

// File: rtl/apb_uart_regbank.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_uart_regbank : APB3 register bank for the UART core (decode + registers)
// Revision         : 1.0
// -----------------------------------------------------------------------------
module apb_uart_regbank
   import uart_apb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 3,
   parameter int                    NUM_REGS    = 6,
   parameter int                    WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0] BAUD_RESET  = '0
) (
   input  logic                  pclk_i,
   input  logic                  preset_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [DATA_WIDTH-1:0] pwdata_i,
   output logic [DATA_WIDTH-1:0] prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [DATA_WIDTH-1:0] baud_val_o,
   output logic [DATA_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_wr_o,
   input  logic [DATA_WIDTH-1:0] rx_data_i,
   output logic                  rx_rd_o,
   input  logic                  tx_rdy_i,
   input  logic                  rx_rdy_i,
   input  logic                  rx_ovr_i,
   output logic                  irq_o
);

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] baud_q, ctrl_q, txdata_q, prdata_q;
   logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];
   logic                  ovr_q, pslverr_q, tx_wr_q, rx_rd_q;

   logic                  w_idle, w_setup, w_enter_ready, w_complete;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [31:0]           w_idx;
   logic                  w_write, w_valid, w_err, w_commit, w_wr_commit, w_clr;
   logic [DATA_WIDTH-1:0] w_rdata;

   apb_wait_ctrl #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctrl (
      .clk_i         (pclk_i),
      .rst_i         (preset_i),
      .psel_i        (psel_i),
      .penable_i     (penable_i),
      .idle_o        (w_idle),
      .setup_o       (w_setup),
      .enter_ready_o (w_enter_ready),
      .pready_o      (pready_o),
      .complete_o    (w_complete)
   );

   // Zero-wait transfers reach READY on the setup edge, before the capture lands.
   assign w_addr      = w_idle ? paddr_i  : addr_q;
   assign w_write     = w_idle ? pwrite_i : write_q;
   assign w_idx       = 32'(w_addr);
   assign w_valid     = (w_idx < NUM_REGS);
   assign w_err       = ~w_valid | (w_write & (w_idx == REG_RXDATA));
   assign w_commit    = w_complete & ~w_err;
   assign w_wr_commit = w_commit & write_q;
   assign w_clr       = w_wr_commit & (w_idx == REG_STATUS) & wdata_q[STAT_OVR];

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         REG_BAUD:   w_rdata = baud_q;
         REG_CTRL:   w_rdata = ctrl_q;
         REG_TXDATA: w_rdata = txdata_q;
         REG_RXDATA: w_rdata = rx_data_i;
         REG_STATUS: begin
            w_rdata[STAT_TX_RDY] = tx_rdy_i;
            w_rdata[STAT_RX_RDY] = rx_rdy_i;
            w_rdata[STAT_OVR]    = ovr_q;
         end
         default:    if (w_valid) w_rdata = scratch_q[w_addr];
      endcase
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         baud_q    <= BAUD_RESET;
         ctrl_q    <= '0;
         txdata_q  <= '0;
         ovr_q     <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         tx_wr_q   <= 1'b0;
         rx_rd_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) scratch_q[i] <= '0;
      end else begin
         if (w_setup) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
         end
         prdata_q  <= (w_enter_ready && !w_write) ? w_rdata : '0;
         pslverr_q <= w_enter_ready & w_err;
         tx_wr_q   <= w_wr_commit & (w_idx == REG_TXDATA);
         rx_rd_q   <= w_commit & ~write_q & (w_idx == REG_RXDATA);
         // A receiver overrun on the clearing edge must not be lost.
         ovr_q     <= rx_ovr_i | (ovr_q & ~w_clr);
         if (w_wr_commit) begin
            case (w_idx)
               REG_BAUD:   baud_q   <= wdata_q;
               REG_CTRL:   ctrl_q   <= wdata_q;
               REG_TXDATA: txdata_q <= wdata_q;
               default:    if (w_idx >= REG_FIRST_SCRATCH) scratch_q[w_addr] <= wdata_q;
            endcase
         end
      end
   end

   assign prdata_o   = prdata_q;
   assign pslverr_o  = pslverr_q;
   assign baud_val_o = baud_q;
   assign ctrl_o     = ctrl_q;
   assign tx_data_o  = txdata_q;
   assign tx_wr_o    = tx_wr_q;
   assign rx_rd_o    = rx_rd_q;
   assign irq_o      = (ctrl_q[CTRL_RX_IE]  & rx_rdy_i) |
                       (ctrl_q[CTRL_TX_IE]  & tx_rdy_i) |
                       (ctrl_q[CTRL_OVR_IE] & ovr_q);

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_regbank.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_apb_uart_regbank : scoreboard bench, zero-wait and three-wait instances
// Revision            : 1.0
// -----------------------------------------------------------------------------
module tb_apb_uart_regbank;

   logic       clk, rst, psel0, psel3, penable, pwrite, tx_rdy, rx_rdy, rx_ovr;
   logic [2:0] paddr;
   logic [7:0] pwdata, rx_data;
   logic [7:0] prdata0, baud0, ctrl0, txd0, prdata3, baud3, ctrl3, txd3;
   logic       pready0, pslverr0, tx_wr0, rx_rd0, irq0;
   logic       pready3, pslverr3, tx_wr3, rx_rd3, irq3;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic [7:0] waits;
      logic [7:0] leak;
   } res_t;

   typedef struct {
      string      name;
      logic [7:0] mask;
      logic [7:0] rdata;
      logic       err;
      logic [7:0] waits;
   } exp_t;

   exp_t exp_q[$];
   res_t res_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   apb_uart_regbank #(
      .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(6), .WAIT_STATES(0), .BAUD_RESET(8'h1A)
   ) dut0 (
      .pclk_i(clk), .preset_i(rst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0),
      .pslverr_o(pslverr0), .baud_val_o(baud0), .ctrl_o(ctrl0), .tx_data_o(txd0),
      .tx_wr_o(tx_wr0), .rx_data_i(rx_data), .rx_rd_o(rx_rd0), .tx_rdy_i(tx_rdy),
      .rx_rdy_i(rx_rdy), .rx_ovr_i(rx_ovr), .irq_o(irq0)
   );

   apb_uart_regbank #(
      .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(6), .WAIT_STATES(3), .BAUD_RESET(8'h00)
   ) dut3 (
      .pclk_i(clk), .preset_i(rst), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata3), .pready_o(pready3),
      .pslverr_o(pslverr3), .baud_val_o(baud3), .ctrl_o(ctrl3), .tx_data_o(txd3),
      .tx_wr_o(tx_wr3), .rx_data_i(rx_data), .rx_rd_o(rx_rd3), .tx_rdy_i(tx_rdy),
      .rx_rdy_i(rx_rdy), .rx_ovr_i(rx_ovr), .irq_o(irq3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One APB transfer on instance d (0 or 3-wait); observation goes to res_q.
   task automatic xfer(input bit d, input logic wr, input logic [2:0] a, input logic [7:0] wd,
                       input bit ovr_at_done);
      res_t r;
      r.rdata = '0; r.err = 1'b0; r.waits = '0; r.leak = '0;
      if (d) psel3 = 1'b1; else psel0 = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      while (((d ? pready3 : pready0) !== 1'b1) && (r.waits < 8'd50)) begin
         r.leak = r.leak | (d ? prdata3 : prdata0);
         @(posedge clk); #1;
         r.waits = r.waits + 8'd1;
      end
      r.rdata = d ? prdata3 : prdata0;
      r.err   = d ? pslverr3 : pslverr0;
      if (ovr_at_done) rx_ovr = 1'b1;
      @(posedge clk); #1;
      rx_ovr = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      res_q.push_back(r);
   endtask

   task automatic issue(input bit d, input logic wr, input logic [2:0] a, input logic [7:0] wd,
                        input bit ovr, input string nm, input logic [7:0] erd, input logic eerr);
      exp_t e;
      e.name  = nm;
      e.mask  = wr ? 8'h00 : 8'hFF;
      e.rdata = erd & e.mask;
      e.err   = eerr;
      e.waits = d ? 8'd3 : 8'd0;
      exp_q.push_back(e);
      xfer(d, wr, a, wd, ovr);
   endtask

   task automatic drain_scoreboard();
      exp_t e;
      res_t r;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (res_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no response observed", e.name);
         end else begin
            r = res_q.pop_front();
            if ({r.rdata & e.mask, r.err, r.waits, r.leak} !== {e.rdata, e.err, e.waits, 8'h00}) begin
               n_fail++;
               $display("FAIL %s: got rd=%h err=%b waits=%0d idle_rd=%h, want rd=%h err=%b waits=%0d idle_rd=00",
                        e.name, r.rdata & e.mask, r.err, r.waits, r.leak, e.rdata, e.err, e.waits);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      rx_data = '0; tx_rdy = 0; rx_rdy = 0; rx_ovr = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++;
      if ({pready0, pslverr0, prdata0, baud0, ctrl0, txd0, tx_wr0, rx_rd0, irq0} !==
          {1'b0, 1'b0, 8'h00, 8'h1A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_dut0: got rdy=%b err=%b rd=%h baud=%h ctrl=%h tx=%h want 0 0 00 1a 00 00",
                  pready0, pslverr0, prdata0, baud0, ctrl0, txd0);
      end
      n_cmp++;
      if ({pready3, pslverr3, prdata3, baud3, ctrl3, txd3, tx_wr3, rx_rd3, irq3} !==
          {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_dut3: got rdy=%b err=%b rd=%h baud=%h ctrl=%h tx=%h want all zero",
                  pready3, pslverr3, prdata3, baud3, ctrl3, txd3);
      end
      issue(0, 0, 3'd0, 8'h00, 0, "baud_reset_read", 8'h1A, 1'b0);
      drain_scoreboard();
   endtask

   task automatic test_wait_states();
      issue(1, 1, 3'd1, 8'h55, 0, "ctrl_write_ws3", 8'h00, 1'b0);
      n_cmp++;
      if ({ctrl3, pready3} !== {8'h55, 1'b0}) begin
         n_fail++;
         $display("FAIL ctrl_after_write: got ctrl=%h pready=%b want ctrl=55 pready=0", ctrl3, pready3);
      end
      issue(1, 0, 3'd1, 8'h00, 0, "ctrl_read_ws3", 8'h55, 1'b0);
      drain_scoreboard();
   endtask

   task automatic test_tx_rx();
      issue(1, 1, 3'd2, 8'hA5, 0, "txdata_write", 8'h00, 1'b0);
      n_cmp++;
      if ({tx_wr3, txd3} !== {1'b1, 8'hA5}) begin
         n_fail++;
         $display("FAIL tx_wr_pulse: got tx_wr=%b tx_data=%h want 1 a5", tx_wr3, txd3);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (tx_wr3 !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_wr_single: got %b want 0", tx_wr3);
      end
      issue(1, 0, 3'd2, 8'h00, 0, "txdata_read", 8'hA5, 1'b0);
      rx_data = 8'h3C;
      issue(1, 0, 3'd3, 8'h00, 0, "rxdata_read", 8'h3C, 1'b0);
      n_cmp++;
      if ({rx_rd3, tx_wr3} !== 2'b10) begin
         n_fail++;
         $display("FAIL rx_rd_pulse: got rx_rd=%b tx_wr=%b want 1 0", rx_rd3, tx_wr3);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rx_rd3 !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_rd_single: got %b want 0", rx_rd3);
      end
      issue(1, 1, 3'd3, 8'h11, 0, "rxdata_write_err", 8'h00, 1'b1);
      n_cmp++;
      if ({rx_rd3, tx_wr3, txd3} !== {1'b0, 1'b0, 8'hA5}) begin
         n_fail++;
         $display("FAIL rxdata_write_side: got rx_rd=%b tx_wr=%b tx_data=%h want 0 0 a5", rx_rd3, tx_wr3, txd3);
      end
      drain_scoreboard();
   endtask

   task automatic test_overrun();
      tx_rdy = 1'b1;
      issue(1, 1, 3'd1, 8'h04, 0, "ctrl_ovr_ie", 8'h00, 1'b0);
      rx_ovr = 1'b1;
      @(posedge clk); #1;
      rx_ovr = 1'b0;
      n_cmp++;
      if (irq3 !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_on_ovr: got %b want 1", irq3);
      end
      issue(1, 0, 3'd4, 8'h00, 0, "status_ovr_set", 8'h05, 1'b0);
      issue(1, 1, 3'd4, 8'h04, 1, "status_clr_vs_set", 8'h00, 1'b0);
      issue(1, 0, 3'd4, 8'h00, 0, "status_set_wins", 8'h05, 1'b0);
      n_cmp++;
      if (irq3 !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set_wins: got %b want 1", irq3);
      end
      issue(1, 1, 3'd4, 8'hFB, 0, "status_w0_noclr", 8'h00, 1'b0);
      issue(1, 0, 3'd4, 8'h00, 0, "status_still_set", 8'h05, 1'b0);
      issue(1, 1, 3'd4, 8'h04, 0, "status_clear", 8'h00, 1'b0);
      issue(1, 0, 3'd4, 8'h00, 0, "status_cleared", 8'h01, 1'b0);
      n_cmp++;
      if (irq3 !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_cleared: got %b want 0", irq3);
      end
      drain_scoreboard();
   endtask

   task automatic test_bad_addr();
      issue(1, 1, 3'd7, 8'hFF, 0, "bad_addr_write", 8'h00, 1'b1);
      n_cmp++;
      if ({tx_wr3, rx_rd3, ctrl3, txd3, baud3} !== {1'b0, 1'b0, 8'h04, 8'hA5, 8'h00}) begin
         n_fail++;
         $display("FAIL bad_addr_side: got tx_wr=%b rx_rd=%b ctrl=%h tx=%h baud=%h want 0 0 04 a5 00",
                  tx_wr3, rx_rd3, ctrl3, txd3, baud3);
      end
      issue(1, 0, 3'd7, 8'h00, 0, "bad_addr_read", 8'h00, 1'b1);
      n_cmp++;
      if (rx_rd3 !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_addr_rx_rd: got %b want 0", rx_rd3);
      end
      issue(1, 1, 3'd5, 8'h3E, 0, "scratch_write", 8'h00, 1'b0);
      issue(1, 0, 3'd5, 8'h00, 0, "scratch_read", 8'h3E, 1'b0);
      drain_scoreboard();
   endtask

   task automatic test_back_to_back();
      issue(0, 1, 3'd1, 8'h02, 0, "b2b_ctrl_write", 8'h00, 1'b0);
      issue(0, 1, 3'd5, 8'h77, 0, "b2b_scratch_write", 8'h00, 1'b0);
      issue(0, 0, 3'd5, 8'h00, 0, "b2b_scratch_read", 8'h77, 1'b0);
      issue(0, 0, 3'd0, 8'h00, 0, "b2b_baud_read", 8'h1A, 1'b0);
      n_cmp++;
      if ({ctrl0, irq0} !== {8'h02, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_tx_irq: got ctrl=%h irq=%b want 02 1", ctrl0, irq0);
      end
      drain_scoreboard();
   endtask

   task automatic test_reset_mid_transfer();
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h99;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({pready3, pslverr3, prdata3, tx_wr3, rx_rd3, txd3, ctrl3, baud3, irq3} !==
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset_state: got rdy=%b err=%b rd=%h tx_wr=%b tx=%h ctrl=%h want all zero",
                  pready3, pslverr3, prdata3, tx_wr3, txd3, ctrl3);
      end
      rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({tx_wr3, txd3} !== {1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset_no_tx_wr: got tx_wr=%b tx=%h want 0 00", tx_wr3, txd3);
      end
      issue(1, 1, 3'd2, 8'h66, 0, "post_reset_tx_write", 8'h00, 1'b0);
      n_cmp++;
      if ({tx_wr3, txd3} !== {1'b1, 8'h66}) begin
         n_fail++;
         $display("FAIL post_reset_tx: got tx_wr=%b tx=%h want 1 66", tx_wr3, txd3);
      end
      drain_scoreboard();
   endtask

   initial begin
      test_reset();
      test_wait_states();
      test_tx_rx();
      test_overrun();
      test_bad_addr();
      test_back_to_back();
      test_reset_mid_transfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
